sc_clock_reset_io_gen: RTL

//   Board-side clock/reset/input generator for the single-cycle computer.

---
 rtl/sc_clock_reset_io_gen.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/sc_clock_reset_io_gen.sv
`default_nettype none
// ============================================================================
// Module   : sc_clock_reset_io_gen
// Purpose  : Board-side clock/reset/input generator for the single-cycle
//            computer. Divides the board clock into mem_clk and a cpu_clk at
//            half the mem_clk rate. cpu_clk can free-run or be single-stepped
//            from a debounced key. The block also sequences the CPU's
//            active-low reset and debounces the slide switches.
// Ports    : clock      - board clock; all logic runs on its rising edge
//            reset      - asynchronous active-high clear of all state
//            run_mode   - 1 = free-run cpu_clk, 0 = single-step (synchronised)
//            step_key   - raw step button, active-high
//            sw_raw     - raw slide switches
//            mem_clk    - memory clock
//            cpu_clk    - CPU clock; every edge coincides with a mem_clk rise
//            resetn_out - active-low CPU reset
//            sw_db      - debounced switches
//            sw_chg     - one-clock pulse per channel when sw_db changes
//            step_busy  - high while a requested single step is in progress
// Revision : 1.0 - initial release
// ============================================================================
module sc_clock_reset_io_gen #(
  parameter int MEM_DIV   = 1,
  parameter int RST_HOLD  = 4,
  parameter int SW_WIDTH  = 10,
  parameter int DB_CYCLES = 16
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                run_mode,
  input  logic                step_key,
  input  logic [SW_WIDTH-1:0] sw_raw,
  output logic                mem_clk,
  output logic                cpu_clk,
  output logic                resetn_out,
  output logic [SW_WIDTH-1:0] sw_db,
  output logic [SW_WIDTH-1:0] sw_chg,
  output logic                step_busy
);

  localparam int c_div_w  = (MEM_DIV > 1) ? $clog2(MEM_DIV) : 1;
  localparam int c_rst_w  = $clog2(RST_HOLD + 1);
  localparam int c_db_w   = $clog2(DB_CYCLES);
  localparam int c_n_db   = SW_WIDTH + 1;

  localparam logic [c_div_w-1:0] c_div_last = c_div_w'(MEM_DIV - 1);
  localparam logic [c_rst_w-1:0] c_rst_hold = c_rst_w'(RST_HOLD);
  localparam logic [c_db_w-1:0]  c_db_last  = c_db_w'(DB_CYCLES - 1);

  // --------------------------------------------------------------------------
  // Debounce: switch channels plus the step key as the top channel.
  // --------------------------------------------------------------------------
  logic [c_n_db-1:0] w_raw;
  logic [c_n_db-1:0] w_db;
  logic [c_n_db-1:0] w_chg;

  assign w_raw = {step_key, sw_raw};

  for (genvar gi = 0; gi < c_n_db; gi++) begin : g_db
    logic              r_s1;
    logic              r_s2;
    logic              r_db;
    logic              r_chg;
    logic [c_db_w-1:0] r_cnt;

    always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
        r_s1  <= 1'b0;
        r_s2  <= 1'b0;
        r_db  <= 1'b0;
        r_chg <= 1'b0;
        r_cnt <= '0;
      end else begin
        r_s1  <= w_raw[gi];
        r_s2  <= r_s1;
        r_chg <= 1'b0;
        if (r_s2 != r_db) begin
          // Accept only after DB_CYCLES consecutive differing samples;
          // any sample equal to r_db restarts the count.
          if (r_cnt == c_db_last) begin
            r_db  <= r_s2;
            r_cnt <= '0;
            r_chg <= 1'b1;
          end else begin
            r_cnt <= r_cnt + c_db_w'(1);
          end
        end else begin
          r_cnt <= '0;
        end
      end
    end

    assign w_db[gi]  = r_db;
    assign w_chg[gi] = r_chg;
  end

  // --------------------------------------------------------------------------
  // Clock divider, cpu_clk control, step handshake and reset sequencer
  // --------------------------------------------------------------------------
  logic               r_run_s1;
  logic               r_run_s2;
  logic [c_div_w-1:0] r_div_cnt;
  logic               r_mem_clk;
  logic               r_cpu_clk;
  logic               r_step_busy;
  logic [c_rst_w-1:0] r_rst_cnt;
  logic               r_resetn;

  logic w_wrap;
  logic w_rise;
  logic w_cpu_tog;
  logic w_cpu_up;
  logic w_cpu_down;
  logic w_step_press;

  assign w_wrap     = (r_div_cnt == c_div_last);
  assign w_rise     = w_wrap & ~r_mem_clk;
  // A high cpu_clk always completes its low transition, so leaving run mode
  // mid-pulse never truncates the pulse or parks the clock high.
  assign w_cpu_tog  = w_rise & (r_run_s2 | r_step_busy | r_cpu_clk);
  assign w_cpu_up   = w_cpu_tog & ~r_cpu_clk;
  assign w_cpu_down = w_cpu_tog & r_cpu_clk;
  // Debounced key just went 0->1: its change pulse coincides with the new level.
  assign w_step_press = w_chg[SW_WIDTH] & w_db[SW_WIDTH];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_run_s1    <= 1'b0;
      r_run_s2    <= 1'b0;
      r_div_cnt   <= '0;
      r_mem_clk   <= 1'b0;
      r_cpu_clk   <= 1'b0;
      r_step_busy <= 1'b0;
      r_rst_cnt   <= '0;
      r_resetn    <= 1'b0;
    end else begin
      r_run_s1 <= run_mode;
      r_run_s2 <= r_run_s1;

      if (w_wrap) begin
        r_div_cnt <= '0;
        r_mem_clk <= ~r_mem_clk;
      end else begin
        r_div_cnt <= r_div_cnt + c_div_w'(1);
      end

      if (w_cpu_tog) begin
        r_cpu_clk <= ~r_cpu_clk;
      end

      // Presses while busy are dropped; a fresh press wins over a fall that
      // merely finishes a pulse left over from run mode.
      if (w_step_press && !r_run_s2 && !r_step_busy) begin
        r_step_busy <= 1'b1;
      end else if (w_cpu_down) begin
        r_step_busy <= 1'b0;
      end

      if (w_cpu_up && (r_rst_cnt != c_rst_hold)) begin
        r_rst_cnt <= r_rst_cnt + c_rst_w'(1);
      end

      if (w_cpu_down && (r_rst_cnt == c_rst_hold)) begin
        r_resetn <= 1'b1;
      end
    end
  end

  assign mem_clk    = r_mem_clk;
  assign cpu_clk    = r_cpu_clk;
  assign resetn_out = r_resetn;
  assign step_busy  = r_step_busy;
  assign sw_db      = w_db[SW_WIDTH-1:0];
  assign sw_chg     = w_chg[SW_WIDTH-1:0];

endmodule
`default_nettype wire
